// File: rtl/matmul_pkg.sv
// matmul_pkg: shared widths, FSM states and address helper
// for the 8x8 signed matrix multiplier read/MAC engine.
package matmul_pkg;

  localparam int N    = 8;
  localparam int DW   = 8;
  localparam int AW   = 6;
  localparam int ACCW = 19;

  typedef logic [AW-1:0]          addr_t;
  typedef logic signed [DW-1:0]   data_t;
  typedef logic signed [ACCW-1:0] acc_t;
  typedef logic [2:0]             idx_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WR0,
    WR1,
    DONE
  } state_e;

  // Row-major address of element (r, c): r*N + c.
  function automatic addr_t rc_addr(idx_t r, idx_t c);
    return {r, c};
  endfunction

endpackage

// File: rtl/matmul_reader_if.sv
// matmul_reader_if: controller handshake plus A/B operand RAM
// read buses and result RAM write bus of the matmul reader.
//   master: the reader (drives addresses, busy/done, C writes)
//   slave : controller + RAMs (drive start and read data)
interface matmul_reader_if;
  import matmul_pkg::*;

  logic  start;
  logic  busy;
  logic  done;
  addr_t a_addr;
  data_t a_dout;
  addr_t b_addr1;
  addr_t b_addr2;
  data_t b_dout1;
  data_t b_dout2;
  logic  ab_mwr;
  addr_t c_addr;
  acc_t  c_mdi;
  logic  c_mwr;

  modport master (
    input  start,
    input  a_dout,
    input  b_dout1,
    input  b_dout2,
    output busy,
    output done,
    output a_addr,
    output b_addr1,
    output b_addr2,
    output ab_mwr,
    output c_addr,
    output c_mdi,
    output c_mwr
  );

  modport slave (
    output start,
    output a_dout,
    output b_dout1,
    output b_dout2,
    input  busy,
    input  done,
    input  a_addr,
    input  b_addr1,
    input  b_addr2,
    input  ab_mwr,
    input  c_addr,
    input  c_mdi,
    input  c_mwr
  );

endinterface

// File: rtl/matmul_reader_mac_lane.sv
// mac_lane: one signed DW x DW multiply feeding an ACCW accumulator.
// Ports: clk, rst_n, clr_i (zero acc), en_i (accumulate), a_i, b_i, acc_o.
module mac_lane
  import matmul_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  en_i,
  input  data_t a_i,
  input  data_t b_i,
  output acc_t  acc_o
);

  logic signed [2*DW-1:0] prod;
  acc_t                   prod_x;
  acc_t                   acc_q;
  acc_t                   acc_d;

  assign prod   = a_i * b_i;
  assign prod_x = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

  // Clear wins over enable so a new dot product never
  // picks up a stale partial sum.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_reader.sv
// matmul_reader: sequences A/B RAM reads, accumulates two dot products
// per pass and writes C = A x B to the result RAM.
// Ports: clk, reset_n (async, active-low), bus (matmul_reader_if.master).
module matmul_reader
  import matmul_pkg::*;
(
  input logic       clk,
  input logic       reset_n,
  matmul_reader_if.master bus
);

  state_e state_q;
  state_e state_d;
  idx_t   i_q;
  idx_t   i_d;
  idx_t   j_q;
  idx_t   j_d;
  idx_t   k_q;
  idx_t   k_d;
  logic   vld_q;
  logic   clr;

  acc_t  acc1;
  acc_t  acc2;
  addr_t a_addr;
  addr_t b_addr1;
  addr_t b_addr2;
  addr_t c_addr;
  acc_t  c_mdi;
  logic  c_mwr;
  logic  done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      // RAM data lags its address by one cycle.
      vld_q   <= (state_q == READ);
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    clr     = 1'b0;
    a_addr  = '0;
    b_addr1 = '0;
    b_addr2 = '0;
    c_addr  = '0;
    c_mdi   = '0;
    c_mwr   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          clr     = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      READ: begin
        a_addr  = rc_addr(i_q, k_q);
        b_addr1 = rc_addr(k_q, j_q);
        b_addr2 = rc_addr(k_q, j_q | 3'd1);
        if (k_q == 3'd7) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      DRAIN: begin
        state_d = WR0;
      end
      WR0: begin
        c_addr  = rc_addr(i_q, j_q);
        c_mdi   = acc1;
        c_mwr   = 1'b1;
        state_d = WR1;
      end
      WR1: begin
        c_addr = rc_addr(i_q, j_q | 3'd1);
        c_mdi  = acc2;
        c_mwr  = 1'b1;
        if (i_q == 3'd7 && j_q == 3'd6) begin
          state_d = DONE;
        end else begin
          // Next pair: clear the lanes on the way into READ.
          state_d = READ;
          clr     = 1'b1;
          if (j_q == 3'd6) begin
            j_d = '0;
            i_d = i_q + 3'd1;
          end else begin
            j_d = j_q + 3'd2;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        i_d     = '0;
        j_d     = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  mac_lane u_lane1 (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (clr),
    .en_i  (vld_q),
    .a_i   (bus.a_dout),
    .b_i   (bus.b_dout1),
    .acc_o (acc1)
  );

  mac_lane u_lane2 (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (clr),
    .en_i  (vld_q),
    .a_i   (bus.a_dout),
    .b_i   (bus.b_dout2),
    .acc_o (acc2)
  );

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done;
  assign bus.a_addr  = a_addr;
  assign bus.b_addr1 = b_addr1;
  assign bus.b_addr2 = b_addr2;
  assign bus.ab_mwr  = 1'b0;
  assign bus.c_addr  = c_addr;
  assign bus.c_mdi   = c_mdi;
  assign bus.c_mwr   = c_mwr;

endmodule

// File: tb/tb_matmul_reader.sv
// tb_matmul_reader: RAM models plus scoreboard of C writes
// against a behavioural 8x8 signed matrix product.
module tb_matmul_reader;
  import matmul_pkg::*;

  typedef struct {
    addr_t addr;
    acc_t  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  matmul_reader_if bus ();

  matmul_reader dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  data_t amem [64];
  data_t bmem [64];
  acc_t  cmem [64];
  wr_t   exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  always @(posedge clk) begin
    if (!bus.ab_mwr) begin
      bus.a_dout  <= amem[bus.a_addr];
      bus.b_dout1 <= bmem[bus.b_addr1];
      bus.b_dout2 <= bmem[bus.b_addr2];
    end
    if (bus.c_mwr) cmem[bus.c_addr] <= bus.c_mdi;
  end

  task automatic load_model();
    int  s;
    wr_t w;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        s = 0;
        for (int k = 0; k < 8; k++)
          s += int'(amem[i*8+k]) * int'(bmem[k*8+j]);
        w.addr = addr_t'(i*8 + j);
        w.data = acc_t'(s);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 64; a++) begin
      amem[a] = data_t'($urandom_range(255, 0));
      bmem[a] = data_t'($urandom_range(255, 0));
    end
  endtask

  task automatic run_check(input string name);
    int    cyc;
    int    wr_cnt = 0;
    int    done_cnt = 0;
    int    done_cyc = -1;
    int    busy_err = 0;
    int    ab_err = 0;
    int    first_cyc = -1;
    addr_t first_addr = '1;
    wr_t   e;
    load_model();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cyc = 1;
    while (cyc <= 360) begin
      if (bus.ab_mwr !== 1'b0) ab_err++;
      if (bus.busy !== (cyc <= 353)) busy_err++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.c_mwr === 1'b1) begin
        if (wr_cnt == 0) begin
          first_cyc  = cyc;
          first_addr = bus.c_addr;
        end
        wr_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra write addr=%0d data=%0d, required none",
                   name, bus.c_addr, bus.c_mdi);
        end else begin
          e = exp_q.pop_front();
          if (bus.c_addr !== e.addr || bus.c_mdi !== e.data) begin
            miscompares++;
            $display("FAIL %s write addr=%0d data=%0d, required addr=%0d data=%0d",
                     name, bus.c_addr, bus.c_mdi, e.addr, e.data);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (wr_cnt !== 64) begin
      miscompares++;
      $display("FAIL %s write count %0d, required 64", name, wr_cnt);
    end
    vectors++;
    if (done_cnt !== 1 || done_cyc !== 353) begin
      miscompares++;
      $display("FAIL %s done pulses=%0d last cycle=%0d, required 1 at 353",
               name, done_cnt, done_cyc);
    end
    vectors++;
    if (busy_err !== 0) begin
      miscompares++;
      $display("FAIL %s busy wrong in %0d cycles, required 0", name, busy_err);
    end
    vectors++;
    if (ab_err !== 0) begin
      miscompares++;
      $display("FAIL %s ab_mwr high in %0d cycles, required 0", name, ab_err);
    end
    vectors++;
    if (first_cyc !== 10 || first_addr !== addr_t'(0)) begin
      miscompares++;
      $display("FAIL %s first write cycle=%0d addr=%0d, required 10 addr 0",
               name, first_cyc, first_addr);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.a_addr, bus.b_addr1, bus.b_addr2, bus.ab_mwr,
         bus.c_addr, bus.c_mdi, bus.c_mwr} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs busy=%b done=%b a=%0d b1=%0d b2=%0d c=%0d mdi=%0d mwr=%b, required all 0",
               bus.busy, bus.done, bus.a_addr, bus.b_addr1, bus.b_addr2,
               bus.c_addr, bus.c_mdi, bus.c_mwr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    acc_t e;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        amem[r*8+c] = (r == c) ? data_t'(1) : data_t'(0);
        bmem[r*8+c] = data_t'(r*8 + c - 32);
      end
    end
    run_check("identity");
    for (int a = 0; a < 64; a++) begin
      e = acc_t'(a - 32);
      vectors++;
      if (cmem[a] !== e) begin
        miscompares++;
        $display("FAIL identity C[%0d]=%0d, required %0d", a, cmem[a], e);
      end
    end
  endtask

  task automatic test_extremes(input int bval, input int cval);
    for (int a = 0; a < 64; a++) begin
      amem[a] = data_t'(-128);
      bmem[a] = data_t'(bval);
    end
    run_check("extremes");
    for (int a = 0; a < 64; a++) begin
      vectors++;
      if (cmem[a] !== acc_t'(cval)) begin
        miscompares++;
        $display("FAIL extremes C[%0d]=%0d, required %0d", a, cmem[a], cval);
      end
    end
  endtask

  task automatic test_start_held();
    int cyc;
    int dn = 0;
    int d1 = -1;
    int d2 = -1;
    int wr = 0;
    logic b354 = 1'bx;
    logic b355 = 1'bx;
    fill_random();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc <= 720) begin
      if (bus.done === 1'b1) begin
        dn++;
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
      if (bus.c_mwr === 1'b1 && cyc <= 353) wr++;
      if (cyc == 354) b354 = bus.busy;
      if (cyc == 355) b355 = bus.busy;
      if (cyc == 400) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (dn !== 2 || d1 !== 353 || d2 !== 707) begin
      miscompares++;
      $display("FAIL held_start done count=%0d at %0d,%0d, required 2 at 353,707",
               dn, d1, d2);
    end
    vectors++;
    if (wr !== 64) begin
      miscompares++;
      $display("FAIL held_start first run writes=%0d, required 64", wr);
    end
    vectors++;
    if (b354 !== 1'b0 || b355 !== 1'b1) begin
      miscompares++;
      $display("FAIL held_start busy at 354/355=%b%b, required 01", b354, b355);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int dn = 0;
    int bz = 0;
    fill_random();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cyc = 1;
    while (cyc < 150) begin
      if (bus.done === 1'b1) dn++;
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.a_addr, bus.b_addr1, bus.b_addr2, bus.ab_mwr,
         bus.c_addr, bus.c_mdi, bus.c_mwr} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset outputs busy=%b a=%0d b1=%0d b2=%0d c=%0d mdi=%0d mwr=%b, required all 0",
               bus.busy, bus.a_addr, bus.b_addr1, bus.b_addr2,
               bus.c_addr, bus.c_mdi, bus.c_mwr);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    rst_n = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
      if (bus.busy !== 1'b0) bz++;
    end
    vectors++;
    if (dn !== 0 || bz !== 0) begin
      miscompares++;
      $display("FAIL mid_reset done pulses=%0d busy cycles=%0d, required 0 and 0",
               dn, bz);
    end
    run_check("after_reset");
  endtask

  task automatic test_random();
    for (int s = 0; s < 20; s++) begin
      fill_random();
      run_check($sformatf("random%0d", s));
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_extremes(-128, 131072);
    test_extremes(127, -130048);
    test_start_held();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_reader.md
# matmul_reader

Read-side sequencer and MAC engine for the 8x8 signed matrix multiplier. It drives the read addresses of the operand RAMs for A and B. Both RAMs are registered-output with 1-cycle read latency, and read only while their write enable is low. The block accumulates dot products and streams C = A x B into the result RAM, two elements per pass. It sits between the operand RAMs and the result RAM and is kicked off by the top-level controller.

## Interface
- N, 8, matrix dimension (fixed; row-major addressing, addr = row*N + col)
- DW, 8, signed operand width
- AW, 6, RAM address width
- ACCW, 19, signed accumulator / result width
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last C element has been written
- a_addr  out  AW  A RAM read address (wire to addr1 of A RAM)
- a_dout  in  DW  A RAM data_out1, signed
- b_addr1  out  AW  B RAM port-1 read address
- b_addr2  out  AW  B RAM port-2 read address
- b_dout1  in  DW  B RAM data_out1, signed
- b_dout2  in  DW  B RAM data_out2, signed
- ab_mwr  out  1  write enable to A and B RAMs; constantly 0
- c_addr  out  AW  result RAM write address
- c_mdi  out  ACCW  result write data, signed
- c_mwr  out  1  result RAM write strobe

## Operation
- FSM states:
  - IDLE -> READ on start.
  - READ: 8 cycles, k = 0..7. Issue a_addr = i*8+k, b_addr1 = k*8+j, b_addr2 = k*8+j+1.
  - DRAIN: 1 cycle.
  - WR0: c_addr = i*8+j, c_mdi = acc1, c_mwr = 1.
  - WR1: c_addr = i*8+j+1, c_mdi = acc2, c_mwr = 1.
  - After WR1: back to READ for the next pair, or to DONE after pair (i=7, j=6).
  - DONE: 1 cycle, done = 1. Then IDLE.
- Pair order: j steps 0, 2, 4, 6 within row i; i steps 0..7. 32 pairs in total.
- Accumulation:
  - A one-cycle-delayed valid flag (READ registered) qualifies data.
  - On each valid cycle: acc1 += a_dout*b_dout1 and acc2 += a_dout*b_dout2.
  - Products are sign-extended from 16 to ACCW bits.
  - acc1 and acc2 clear when entering READ with k = 0.
- Width: |sum| <= 8*128*128 = 131072, so no overflow in 19 bits. No saturation logic.
- start while busy: ignored. No queuing.
- Outside READ: a_addr, b_addr1 and b_addr2 are 0. Outside WR0/WR1: c_mwr = 0 and c_mdi = 0.
- Reset, including mid-run: FSM goes to IDLE, counters and accumulators go to 0, all outputs go to 0. No done pulse is issued. Partially written C contents are left as-is.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE.
- Pair p occupies cycles 11p+1 .. 11p+11:
  - READ at 11p+1..11p+8
  - DRAIN at 11p+9
  - WR0 at 11p+10
  - WR1 at 11p+11
- The address issued in cycle t returns data in cycle t+1, which is accumulated at the end of t+1. The k=7 data is accumulated during DRAIN.
- done is high in cycle 353. busy is high in cycles 1..353. IDLE resumes at cycle 354.
- Back-to-back: a start in cycle 354 begins a new run; a start in cycle 353 is ignored.
- ab_mwr is 0 in every cycle, including reset.

## Structure
- Package matmul_pkg holds:
  - N, DW, AW, ACCW
  - the FSM state enum (IDLE, READ, DRAIN, WR0, WR1, DONE)
  - an addr_t typedef
- Sub-module mac_lane is one signed DW x DW multiply plus ACCW accumulator, with clear and enable inputs. It is instantiated twice (lane 1 for B port 1, lane 2 for B port 2).
- The top level holds the FSM, the i/j/k counters, the valid delay register and the write mux.

## Test plan
- Identity: A = I, B[r][c] = r*8+c-32. Expect C == B at every address, and exactly 64 c_mwr pulses.
- Extremes, case 1: all A = -128 and all B = -128. Expect every c_mdi = 131072.
- Extremes, case 2: A = -128, B = 127. Expect every c_mdi = -130048.
- Cycle accounting: pulse start. Expect busy to rise at cycle 1, c_mwr first at cycle 10 with c_addr 0, done only at cycle 353, and ab_mwr always 0.
- start held high for 400 cycles: exactly one run during cycles 1..353. A second run starts at cycle 354 (start is sampled in IDLE).
- Reset mid-run: drop reset_n at cycle 150. Expect all outputs 0 immediately and no done. After release and a new start, all 64 C values must match the reference model.
- Random signed A and B, 20 seeds: scoreboard the C writes against a behavioural matrix product.
